// File: rtl/pipeline_reg_pkg.sv
// Shared pipeline-register types for the RV32I core.
// if_id_reg_t is the {pc, ir} pair carried across the IF/ID boundary.
package pipeline_reg_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } if_id_reg_t;

    // addi x0, x0, 0: the canonical bubble presented to decode when nothing is held.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/if_id_buffer.sv
// Elastic IF/ID buffer: small FIFO of {pc, ir} pairs between fetch and decode.
// Presents a NOP bubble when empty; flush discards everything on a redirect.
module if_id_buffer
    import pipeline_reg_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  if_id_reg_t               if_reg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output if_id_reg_t               id_reg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    if_id_reg_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             enq;
    logic             deq;

    // Ready/valid derive only from occupancy, so in_ready never waits on decode.
    always_comb begin
        in_ready  = (count_reg < DEPTH_C);
        out_valid = (count_reg != '0);
        enq       = in_valid & in_ready & ~flush;
        deq       = out_valid & out_ready & ~flush;
        id_reg    = '{pc: 32'h0, ir: NOP_INSTR};
        if (out_valid) begin
            id_reg = mem[rd_ptr_reg];
        end
    end

    // Storage is deliberately left untouched on reset/flush; only pointers clear.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr_reg] <= if_reg;
                wr_ptr_reg      <= wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: a queue model predicts every output
// each cycle, and dequeued entries are popped from it and compared.
module tb_if_id_buffer;
    import pipeline_reg_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    if_id_reg_t if_reg;
    logic       out_valid;
    logic       out_ready;
    if_id_reg_t id_reg;
    logic [1:0] count;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .if_reg    (if_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .id_reg    (id_reg),
        .count     (count)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    if_id_reg_t  exp_q[$];
    logic [31:0] out_log[$];
    logic        last_enq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, check at the negedge, advance the model.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic ordy, input logic fl);
        logic       m_ready;
        logic       m_valid;
        if_id_reg_t exp;
        in_valid  = v;
        if_reg    = '{pc: pc, ir: ir};
        out_ready = ordy;
        flush     = fl;
        last_enq  = 1'b0;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            m_ready = (exp_q.size() < DEPTH);
            m_valid = (exp_q.size() != 0);
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("count", 64'(count), 64'(exp_q.size()));
            check("count_le_depth", 64'(count <= 2'(DEPTH)), 64'd1);
            if (!m_valid) begin
                check("id_bubble", 64'(id_reg), {32'h0, NOP_INSTR});
            end else begin
                check("id_head", 64'(id_reg), 64'(exp_q[0]));
            end
            if (fl) begin
                exp_q.delete();
                $display("[TB] flush (in_valid=%0b pc=%h dropped)", v, pc);
            end else begin
                if (m_valid && ordy) begin
                    exp = exp_q.pop_front();
                    check("deq_data", 64'(id_reg), 64'(exp));
                    out_log.push_back(id_reg.pc);
                    $display("[TB] deq pc=%h ir=%h", id_reg.pc, id_reg.ir);
                end
                if (v && m_ready) begin
                    exp_q.push_back('{pc: pc, ir: ir});
                    last_enq = 1'b1;
                    $display("[TB] enq pc=%h ir=%h", pc, ir);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] wrap_pc[10];
        logic [9:0]  ordy_pat;
        int          k;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if_reg = '0;
        @(posedge clk);
        #1;

        // 1. reset with junk on the inputs, then idle
        cycle(1'b1, 32'hDEAD0000, 32'hFFFFFFFF, 1'b1, 1'b0);
        cycle(1'b1, 32'hDEAD0004, 32'hFFFFFFFF, 1'b1, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_ir", 64'(id_reg.ir), 64'(NOP_INSTR));

        // 2. streaming
        cycle(1'b1, 32'h60, 32'h00100093, 1'b1, 1'b0);
        cycle(1'b1, 32'h64, 32'h00200093, 1'b1, 1'b0);
        cycle(1'b1, 32'h68, 32'h00300093, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 3. stall to full, refused third offer, then drain
        cycle(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0);
        cycle(1'b1, 32'h104, 32'h00600093, 1'b0, 1'b0);
        cycle(1'b1, 32'h108, 32'h00700093, 1'b0, 1'b0);
        check("full_refuse", 64'(last_enq), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 4. full with simultaneous dequeue: no bypass
        cycle(1'b1, 32'h180, 32'h00800093, 1'b0, 1'b0);
        cycle(1'b1, 32'h184, 32'h00900093, 1'b0, 1'b0);
        cycle(1'b1, 32'h188, 32'h00A00093, 1'b1, 1'b0);
        check("full_deq_count", 64'(count), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 5. flush with full buffer and an incoming entry, then recover
        cycle(1'b1, 32'h200, 32'h00B00093, 1'b0, 1'b0);
        cycle(1'b1, 32'h204, 32'h00C00093, 1'b0, 1'b0);
        cycle(1'b1, 32'h208, 32'h00D00093, 1'b1, 1'b1);
        check("post_flush_count", 64'(count), 64'd0);
        check("post_flush_ir", 64'(id_reg.ir), 64'(NOP_INSTR));
        cycle(1'b1, 32'h300, 32'h00E00093, 1'b1, 1'b0);
        check("post_flush_head", 64'(id_reg.pc), 64'h300);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // 6. wrap-around with mixed stalls
        out_log.delete();
        for (int i = 0; i < 10; i++) wrap_pc[i] = 32'(i * 4);
        ordy_pat = 10'b1011001101;
        k = 0;
        for (int c = 0; c < 40 && k < 10; c++) begin
            cycle(1'b1, wrap_pc[k], 32'h00000093 | (32'(k) << 20), ordy_pat[c % 10], 1'b0);
            if (last_enq) k++;
        end
        check("wrap_all_enq", 64'(k), 64'd10);
        for (int c = 0; c < 6; c++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("wrap_out_len", 64'(out_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < out_log.size(); i++) begin
            check($sformatf("wrap_pc%0d", i), 64'(out_log[i]), 64'(wrap_pc[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
